// File: rtl/exu_dp_arbiter.sv
// exu_dp_arbiter: shares the EXU ALU datapath among ALU/BJP/MEM/CSR
// and registers the result. DP_ARB_RR_EN selects round-robin arbitration.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_valid_i[3:0]    requests (0=ALU 1=BJP 2=MEM 3=CSR)
//   req_ready_o[3:0]    one-hot accept
//   dp_req_*_o          one-hot datapath selects
//   dp_alu_res_i        datapath ALU result
//   dp_bjp_res_i        datapath BJP result
//   dp_cmp_res_i        datapath branch compare
//   flush_i             pipeline flush
//   rsp_valid_o/ready_i response handshake
//   rsp_id_o            requester index of the response
//   rsp_res_o           registered result
//   rsp_cmp_o           registered compare (BJP only)
module exu_dp_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid_i,
  output logic [3:0]  req_ready_o,
  output logic        dp_req_alu_o,
  output logic        dp_req_bjp_o,
  output logic        dp_req_mem_o,
  output logic        dp_req_csr_o,
  input  logic [31:0] dp_alu_res_i,
  input  logic [31:0] dp_bjp_res_i,
  input  logic        dp_cmp_res_i,
  input  logic        flush_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [1:0]  rsp_id_o,
  output logic [31:0] rsp_res_o,
  output logic        rsp_cmp_o
);

  localparam logic [1:0] ID_ALU = 2'd0;
  localparam logic [1:0] ID_BJP = 2'd1;
  localparam logic [1:0] ID_MEM = 2'd2;
  localparam logic [1:0] ID_CSR = 2'd3;

  logic        can_issue;
  logic [3:0]  gnt;
  logic [1:0]  win;
  logic        accept;
  logic [31:0] nxt_res;
  logic        nxt_cmp;

  assign can_issue = ~flush_i
                   & (~rsp_valid_o | rsp_ready_i);

`ifdef DP_ARB_RR_EN
  logic [1:0] ptr;
  logic [1:0] idx;
  logic       found;

  // First valid requester after the last grant.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k + 1);
      if (!found && req_valid_i[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd3;
    end else if (accept) begin
      ptr <= win;
    end
  end
`else
  // Fixed order: BJP > CSR > MEM > ALU.
  always_comb begin
    gnt    = '0;
    gnt[1] = req_valid_i[1];
    gnt[3] = req_valid_i[3] & ~req_valid_i[1];
    gnt[2] = req_valid_i[2] & ~req_valid_i[1]
           & ~req_valid_i[3];
    gnt[0] = req_valid_i[0] & ~req_valid_i[1]
           & ~req_valid_i[3] & ~req_valid_i[2];
  end
`endif

  always_comb begin
    win = ID_ALU;
    unique case (1'b1)
      gnt[0]:  win = ID_ALU;
      gnt[1]:  win = ID_BJP;
      gnt[2]:  win = ID_MEM;
      gnt[3]:  win = ID_CSR;
      default: win = ID_ALU;
    endcase
  end

  assign req_ready_o  = can_issue ? gnt : 4'b0000;
  assign dp_req_alu_o = req_ready_o[0];
  assign dp_req_bjp_o = req_ready_o[1];
  assign dp_req_mem_o = req_ready_o[2];
  assign dp_req_csr_o = req_ready_o[3];

  assign accept = |(req_valid_i & req_ready_o);

  always_comb begin
    nxt_res = dp_alu_res_i;
    nxt_cmp = 1'b0;
    if (win == ID_BJP) begin
      nxt_res = dp_bjp_res_i;
      nxt_cmp = dp_cmp_res_i;
    end
  end

  // Flush beats load, load beats drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_res_o   <= '0;
      rsp_cmp_o   <= 1'b0;
    end else if (flush_i) begin
      rsp_valid_o <= 1'b0;
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
      rsp_id_o    <= win;
      rsp_res_o   <= nxt_res;
      rsp_cmp_o   <= nxt_cmp;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exu_dp_arbiter.sv
// tb_exu_dp_arbiter: directed bench for exu_dp_arbiter.
// Expected values follow the build (DP_ARB_RR_EN or fixed priority).
module tb_exu_dp_arbiter;

`ifdef DP_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic        sel_alu, sel_bjp, sel_mem, sel_csr;
  logic [31:0] alu_res, bjp_res;
  logic        cmp_res;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_res;
  logic        rsp_cmp;
  logic [3:0]  sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign sel = {sel_csr, sel_mem, sel_bjp, sel_alu};

  exu_dp_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .dp_req_alu_o (sel_alu),
    .dp_req_bjp_o (sel_bjp),
    .dp_req_mem_o (sel_mem),
    .dp_req_csr_o (sel_csr),
    .dp_alu_res_i (alu_res),
    .dp_bjp_res_i (bjp_res),
    .dp_cmp_res_i (cmp_res),
    .flush_i      (flush),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_res_o    (rsp_res),
    .rsp_cmp_o    (rsp_cmp)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic rsp(input string tag,
                     input logic v,
                     input logic [1:0] id,
                     input logic [31:0] res,
                     input logic c);
    check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    check({tag, ".id"}, 32'(rsp_id), 32'(id));
    check({tag, ".res"}, rsp_res, res);
    check({tag, ".cmp"}, 32'(rsp_cmp), 32'(c));
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  exp_rdy;
  logic [1:0]  exp_id;
  logic [31:0] exp_res;

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    alu_res   = '0;
    bjp_res   = '0;
    cmp_res   = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    #12;
    rsp("reset", 1'b0, 2'd0, 32'd0, 1'b0);
    check("reset.ready", 32'(req_ready), 32'h0);
    check("reset.sel", 32'(sel), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // ALU alone: 5+7
    @(negedge clk);
    req_valid = 4'b0001;
    alu_res   = 32'd12;
    bjp_res   = 32'hbad0;
    #1;
    check("alu.ready", 32'(req_ready), 32'h1);
    check("alu.sel", 32'(sel), 32'h1);
    edge_wait();
    rsp("alu.rsp", 1'b1, 2'd0, 32'd12, 1'b0);

    // BJP alone
    @(negedge clk);
    req_valid = 4'b0010;
    alu_res   = 32'hdead;
    bjp_res   = 32'h1000;
    cmp_res   = 1'b1;
    #1;
    check("bjp.ready", 32'(req_ready), 32'h2);
    check("bjp.sel", 32'(sel), 32'h2);
    edge_wait();
    rsp("bjp.rsp", 1'b1, 2'd1, 32'h1000, 1'b1);

    // MEM alone, compare must not leak
    @(negedge clk);
    req_valid = 4'b0100;
    alu_res   = 32'h55;
    cmp_res   = 1'b1;
    #1;
    check("mem.ready", 32'(req_ready), 32'h4);
    edge_wait();
    rsp("mem.rsp", 1'b1, 2'd2, 32'h55, 1'b0);

    // Backpressure with everyone requesting
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    alu_res   = 32'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full.ready", 32'(req_ready), 32'h0);
      check("full.sel", 32'(sel), 32'h0);
      edge_wait();
      rsp("full.rsp", 1'b1, 2'd2, 32'h55, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    exp_rdy = RR ? 4'b1000 : 4'b0010;
    exp_id  = RR ? 2'd3 : 2'd1;
    exp_res = RR ? 32'h77 : 32'h1000;
    check("unfull.ready", 32'(req_ready), 32'(exp_rdy));
    edge_wait();
    rsp("unfull.rsp", 1'b1, exp_id, exp_res, !RR);

    // Continuous contention
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      exp_rdy = RR ? (4'b0001 << (i % 4)) : 4'b0010;
      check("stream.ready", 32'(req_ready), 32'(exp_rdy));
      edge_wait();
      check("stream.valid", 32'(rsp_valid), 32'h1);
    end

    // Flush with a response pending
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 4'b0001;
    alu_res   = 32'h99;
    #1;
    check("flush.ready", 32'(req_ready), 32'h0);
    check("flush.sel", 32'(sel), 32'h0);
    edge_wait();
    check("flush.valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("post.ready", 32'(req_ready), 32'h1);
    edge_wait();
    rsp("post.rsp", 1'b1, 2'd0, 32'h99, 1'b0);

    // Drain without a new load keeps data
    @(negedge clk);
    req_valid = 4'b0000;
    alu_res   = 32'h11;
    edge_wait();
    rsp("drain", 1'b0, 2'd0, 32'h99, 1'b0);

    // Load, then async reset mid-cycle
    @(negedge clk);
    req_valid = 4'b0001;
    alu_res   = 32'h42;
    edge_wait();
    rsp("preload", 1'b1, 2'd0, 32'h42, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    rsp("async", 1'b0, 2'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // First grant after reset
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    exp_rdy = RR ? 4'b0001 : 4'b0010;
    check("rst.grant", 32'(req_ready), 32'(exp_rdy));
    @(negedge clk);
    req_valid = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
